// File: rtl/qed_pkg.sv
// qed_pkg: opcodes, instruction field positions and FSM states shared by the QED duplication engine
package qed_pkg;
    localparam logic [5:0] OP_R    = 6'h38;
    localparam logic [5:0] OP_ADDI = 6'h27;
    localparam logic [5:0] OP_ANDI = 6'h29;
    localparam logic [5:0] OP_ORI  = 6'h2A;
    localparam logic [5:0] OP_XORI = 6'h2B;
    localparam logic [5:0] OP_LW   = 6'h21;
    localparam logic [5:0] OP_SW   = 6'h35;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RA_HI  = 20;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 11;
    typedef enum logic {ST_RECORD, ST_REPLAY} state_e;
endpackage

// File: rtl/qed_dup_xform.sv
// qed_dup_xform: classifies an instruction and builds its register/memory remapped duplicate
module qed_dup_xform
    import qed_pkg::*;
#(
    parameter int          REG_HALF   = 16,
    parameter logic [15:0] MEM_OFFSET = 16'h0400
) (
    input  logic [31:0] inst,
    output logic        dup,
    output logic [31:0] xout
);
    logic [5:0] op;
    logic is_r, is_i, is_lw, is_sw;
    logic [4:0] rh, rd_x, ra_x, rb_x;
    logic [15:0] lw_imm, sw_imm;
    assign op = inst[OPC_HI:OPC_LO];
    assign is_r = op == OP_R;
    assign is_i = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI};
    assign is_lw = op == OP_LW;
    assign is_sw = op == OP_SW;
    assign dup = is_r | is_i | is_lw | is_sw;
    assign rh = 5'(REG_HALF);
    assign rd_x = (is_r | is_i | is_lw) ? (inst[RD_HI:RD_LO] | rh) : inst[RD_HI:RD_LO];
    assign ra_x = dup ? (inst[RA_HI:RA_LO] | rh) : inst[RA_HI:RA_LO];
    assign rb_x = (is_r | is_sw) ? (inst[RB_HI:RB_LO] | rh) : inst[RB_HI:RB_LO];
    assign lw_imm = inst[15:0] + MEM_OFFSET;
    // store immediate is split across the rD slot and the low 11 bits
    assign sw_imm = {inst[RD_HI:RD_LO], inst[10:0]} + MEM_OFFSET;
    assign xout = {op, is_sw ? sw_imm[15:11] : rd_x, ra_x,
                   is_lw ? lw_imm : {rb_x, is_sw ? sw_imm[10:0] : inst[10:0]}};
endmodule

// File: rtl/qed_dup_engine.sv
// qed_dup_engine: records duplicable originals into a queue and replays them as QED duplicates
module qed_dup_engine
    import qed_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          MODE       = 0,
    parameter int          DUP_BLOCK  = 4,
    parameter int          REG_HALF   = 16,
    parameter logic [15:0] MEM_OFFSET = 16'h0400,
    parameter logic [31:0] NOP_INST   = 32'h15000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         exec_dup,
    input  logic                         stall_IF,
    input  logic [31:0]                  ifu_qed_instruction,
    output logic [31:0]                  qed_ifu_instruction,
    output logic                         vld_out,
    output logic                         fetch_hold,
    output logic [$clog2(DEPTH+1)-1:0]   dup_count,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    state_e state, state_nxt;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] cnt_nxt;
    logic [31:0] in_x;
    logic in_dup, replay, act, full, push, pop, go, nop_req;
    // duplicates are stored already transformed, so the head drives decode directly
    qed_dup_xform #(.REG_HALF(REG_HALF), .MEM_OFFSET(MEM_OFFSET)) u_xform (
        .inst(ifu_qed_instruction),
        .dup (in_dup),
        .xout(in_x)
    );
    assign replay = state == ST_REPLAY;
    assign act = ena && !stall_IF;
    assign full = dup_count == CW'(DEPTH);
    assign push = act && !replay && in_dup && !full;
    assign pop = act && replay;
    assign cnt_nxt = dup_count + CW'(push);
    assign go = (MODE == 1) ? (cnt_nxt >= CW'(DUP_BLOCK)) : (exec_dup && dup_count != '0);
    assign nop_req = (MODE == 0) && exec_dup && dup_count == '0;
    assign vld_out = ena && replay;
    assign fetch_hold = ena && replay;
    assign qed_ifu_instruction = !ena ? ifu_qed_instruction :
                                 replay ? mem[head] :
                                 nop_req ? NOP_INST : ifu_qed_instruction;
    always_comb begin
        state_nxt = state;
        if (!ena)
            state_nxt = ST_RECORD;
        else if (act)
            state_nxt = replay ? (dup_count <= CW'(1) ? ST_RECORD : ST_REPLAY) : (go ? ST_REPLAY : ST_RECORD);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RECORD;
            head <= '0;
            tail <= '0;
            dup_count <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            overflow <= overflow | (act && !replay && in_dup && full);
            if (!ena) begin
                head <= '0;
                tail <= '0;
                dup_count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop) head <= head + AW'(1);
                dup_count <= cnt_nxt - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) if (push) mem[tail] <= in_x;
endmodule

// File: tb/tb_qed_dup_engine.sv
// tb_qed_dup_engine: directed and randomized checks of qed_dup_engine against a queue-level model
module tb_qed_dup_engine;
    localparam logic [31:0] NOPI = 32'h15000000;
    localparam logic [31:0] OTHR = 32'h0C000001;
    logic clk = 1'b0;
    logic rst, ena, exec_dup, stall_IF;
    logic [31:0] ins, o0, o1, ob;
    logic v0, v1, h0, h1, ov0, ov1, vb, hb, ovb;
    logic [3:0] c0, c1, cb;
    int checks = 0, errors = 0, mode = 0;
    logic [31:0] mq[$];
    bit m_rep, m_ovf;

    always #5 clk = ~clk;

    qed_dup_engine #(.DEPTH(8), .MODE(0)) d0 (
        .clk(clk), .rst(rst), .ena(ena), .exec_dup(exec_dup), .stall_IF(stall_IF),
        .ifu_qed_instruction(ins), .qed_ifu_instruction(o0), .vld_out(v0),
        .fetch_hold(h0), .dup_count(c0), .overflow(ov0)
    );
    qed_dup_engine #(.DEPTH(8), .MODE(1), .DUP_BLOCK(4)) d1 (
        .clk(clk), .rst(rst), .ena(ena), .exec_dup(exec_dup), .stall_IF(stall_IF),
        .ifu_qed_instruction(ins), .qed_ifu_instruction(o1), .vld_out(v1),
        .fetch_hold(h1), .dup_count(c1), .overflow(ov1)
    );

    assign ob = mode != 0 ? o1 : o0;
    assign vb = mode != 0 ? v1 : v0;
    assign hb = mode != 0 ? h1 : h0;
    assign cb = mode != 0 ? c1 : c0;
    assign ovb = mode != 0 ? ov1 : ov0;

    function automatic bit dupable(input logic [31:0] i);
        return i[31:26] inside {6'h38, 6'h27, 6'h29, 6'h2A, 6'h2B, 6'h21, 6'h35};
    endfunction

    // duplicate built straight from the ISA rules: the register fields get bit 4 set
    function automatic logic [31:0] ref_xf(input logic [31:0] i);
        logic [31:0] r = i;
        logic [15:0] imm;
        case (i[31:26])
            6'h38: begin r[25] = 1'b1; r[20] = 1'b1; r[15] = 1'b1; end
            6'h27, 6'h29, 6'h2A, 6'h2B: begin r[25] = 1'b1; r[20] = 1'b1; end
            6'h21: begin r[25] = 1'b1; r[20] = 1'b1; r[15:0] = i[15:0] + 16'h0400; end
            6'h35: begin
                imm = {i[25:21], i[10:0]} + 16'h0400;
                r[20] = 1'b1;
                r[15] = 1'b1;
                r[25:21] = imm[15:11];
                r[10:0] = imm[10:0];
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_out();
        if (!ena) return ins;
        if (m_rep) return mq[0];
        return (mode == 0 && exec_dup && mq.size() == 0) ? NOPI : ins;
    endfunction

    function automatic bit exp_v();
        return ena && m_rep;
    endfunction

    task automatic model_adv;
        bit go;
        if (!rst) begin
            mq.delete();
            m_rep = 0;
            m_ovf = 0;
        end else if (!ena) begin
            mq.delete();
            m_rep = 0;
        end else if (!stall_IF) begin
            if (m_rep) begin
                void'(mq.pop_front());
                m_rep = mq.size() != 0;
            end else begin
                go = mode == 0 && exec_dup && mq.size() != 0;
                if (dupable(ins)) begin
                    if (mq.size() < 8) mq.push_back(ref_xf(ins));
                    else m_ovf = 1;
                end
                if (mode == 1 && mq.size() >= 4) go = 1;
                m_rep = go;
            end
        end
    endtask

    task automatic drive(input bit e, input bit x, input bit s, input logic [31:0] i);
        ena = e;
        exec_dup = x;
        stall_IF = s;
        ins = i;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        model_adv();
    endtask

    task automatic do_reset;
        rst = 1'b0;
        drive(0, 0, 0, OTHR);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(1, 0, 0, 32'hE0642000);
        repeat (2) tick();
        rst = 1'b1;
        drive(0, 0, 0, 32'h12345678);
        #2;
        checks++;
        if (c0 !== 4'd0 || c1 !== 4'd0 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d/%0d ovf=%b/%b want 0 0", c0, c1, ov0, ov1);
        end
        checks++;
        if ((v0 | h0 | v1 | h1) !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: vld=%b/%b hold=%b/%b want 0", v0, v1, h0, h1);
        end
        checks++;
        if (o0 !== ins || o1 !== ins) begin
            errors++;
            $display("FAIL reset_passthru: out=%h/%h want %h", o0, o1, ins);
        end
    endtask

    task automatic test_basic;
        logic [34:0] st[6] = '{{3'b100, 32'hE0642000}, {3'b100, 32'h84640010}, {3'b110, OTHR},
                               {3'b110, OTHR}, {3'b110, OTHR}, {3'b100, OTHR}};
        logic [31:0] seen[$];
        for (int k = 0; k < 6; k++) begin
            drive(st[k][34], st[k][33], st[k][32], st[k][31:0]);
            #2;
            checks++;
            if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                errors++;
                $display("FAIL basic[%0d]: out=%h vld=%b hold=%b want %h %b", k, ob, vb, hb, exp_out(), exp_v());
            end
            if (vb === 1'b1) seen.push_back(ob);
            tick();
            checks++;
            if (cb !== 4'(mq.size()) || ovb !== m_ovf) begin
                errors++;
                $display("FAIL basic_cnt[%0d]: count=%0d ovf=%b want %0d %b", k, cb, ovb, mq.size(), m_ovf);
            end
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== 32'hE274A000 || seen[1] !== 32'h86740410) begin
            errors++;
            $display("FAIL basic_dups: got %0d dups first=%h want 2 dups E274A000 86740410",
                     seen.size(), seen.size() > 0 ? seen[0] : 32'h0);
        end
    endtask

    task automatic test_sw_remap;
        logic [34:0] st[4] = '{{3'b100, 32'hD4032004}, {3'b110, OTHR}, {3'b100, OTHR}, {3'b100, OTHR}};
        int nd = 0;
        for (int k = 0; k < 4; k++) begin
            drive(st[k][34], st[k][33], st[k][32], st[k][31:0]);
            #2;
            checks++;
            if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                errors++;
                $display("FAIL sw[%0d]: out=%h vld=%b hold=%b want %h %b", k, ob, vb, hb, exp_out(), exp_v());
            end
            if (vb === 1'b1) begin
                nd++;
                checks++;
                if (ob !== 32'hD413A404) begin
                    errors++;
                    $display("FAIL sw_dup: out=%h want D413A404", ob);
                end
            end
            tick();
        end
        checks++;
        if (nd != 1 || cb !== 4'd0) begin
            errors++;
            $display("FAIL sw_count: dups=%0d count=%0d want 1 0", nd, cb);
        end
    endtask

    task automatic test_full;
        for (int k = 0; k < 20; k++) begin
            if (k < 9) drive(1, 0, 0, {6'h27, 26'($urandom)});
            else if (k == 9) drive(1, 1, 0, OTHR);
            else drive(1, 1'($urandom), 0, OTHR);
            #2;
            checks++;
            if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                errors++;
                $display("FAIL full[%0d]: out=%h vld=%b hold=%b want %h %b", k, ob, vb, hb, exp_out(), exp_v());
            end
            tick();
            checks++;
            if (cb !== 4'(mq.size()) || ovb !== m_ovf) begin
                errors++;
                $display("FAIL full_cnt[%0d]: count=%0d ovf=%b want %0d %b", k, cb, ovb, mq.size(), m_ovf);
            end
            if (k == 8) begin
                checks++;
                if (c0 !== 4'd8 || ov0 !== 1'b1) begin
                    errors++;
                    $display("FAIL full_limit: count=%0d ovf=%b want 8 1", c0, ov0);
                end
            end
        end
        checks++;
        if (ov0 !== 1'b1) begin
            errors++;
            $display("FAIL full_sticky: ovf=%b want 1", ov0);
        end
    endtask

    task automatic test_stall_empty;
        logic [34:0] st[12] = '{{3'b100, 32'hE0642000}, {3'b100, 32'h84640010}, {3'b100, 32'hD4032004},
                                {3'b110, OTHR}, {3'b100, OTHR}, {3'b101, OTHR}, {3'b101, OTHR},
                                {3'b101, OTHR}, {3'b100, OTHR}, {3'b100, OTHR}, {3'b110, OTHR},
                                {3'b110, OTHR}};
        logic [31:0] held = '0;
        for (int k = 0; k < 12; k++) begin
            drive(st[k][34], st[k][33], st[k][32], st[k][31:0]);
            #2;
            checks++;
            if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                errors++;
                $display("FAIL stall[%0d]: out=%h vld=%b hold=%b want %h %b", k, ob, vb, hb, exp_out(), exp_v());
            end
            if (k == 5) held = ob;
            if (k == 6 || k == 7) begin
                checks++;
                if (ob !== held || cb !== 4'd2 || vb !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: out=%h count=%0d vld=%b want %h 2 1", k, ob, cb, vb, held);
                end
            end
            if (k == 11) begin
                checks++;
                if (ob !== NOPI || vb !== 1'b0) begin
                    errors++;
                    $display("FAIL empty_nop: out=%h vld=%b want %h 0", ob, vb, NOPI);
                end
            end
            tick();
            checks++;
            if (cb !== 4'(mq.size())) begin
                errors++;
                $display("FAIL stall_cnt[%0d]: count=%0d want %0d", k, cb, mq.size());
            end
        end
    endtask

    task automatic test_abort;
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < 6; k++) begin
                if (k < 3) drive(1, 0, 0, {6'h38, 26'($urandom)});
                else if (k == 3) drive(1, 1, 0, OTHR);
                else if (k == 4) drive(v == 1, 0, 0, 32'h12345678);
                else drive(1, 0, 0, 32'h9ABCDEF0);
                rst = !(v == 1 && k == 4);
                #2;
                checks++;
                if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                    errors++;
                    $display("FAIL abort%0d[%0d]: out=%h vld=%b hold=%b want %h %b", v, k, ob, vb, hb, exp_out(), exp_v());
                end
                if (k == 4) begin
                    checks++;
                    if (cb !== 4'd3) begin
                        errors++;
                        $display("FAIL abort%0d_pre: count=%0d want 3", v, cb);
                    end
                end
                if (k == 5) begin
                    checks++;
                    if (cb !== 4'd0 || hb !== 1'b0 || vb !== 1'b0 || ob !== 32'h9ABCDEF0) begin
                        errors++;
                        $display("FAIL abort%0d_post: count=%0d hold=%b vld=%b out=%h want 0 0 0 9ABCDEF0",
                                 v, cb, hb, vb, ob);
                    end
                end
                tick();
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_mode1_block;
        int k = 0, nrep = 0;
        bit hold_now;
        mode = 1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(1, 0, 0, k < 6 ? {6'h27, 5'(k), 5'(k + 1), 16'(k * 3)} : OTHR);
            #2;
            checks++;
            if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                errors++;
                $display("FAIL mode1[%0d]: out=%h vld=%b hold=%b want %h %b", c, ob, vb, hb, exp_out(), exp_v());
            end
            if (vb === 1'b1) nrep++;
            hold_now = hb;
            tick();
            checks++;
            if (cb !== 4'(mq.size())) begin
                errors++;
                $display("FAIL mode1_cnt[%0d]: count=%0d want %0d", c, cb, mq.size());
            end
            if (!hold_now && k < 6) k++;
        end
        checks++;
        if (nrep != 4 || c1 !== 4'd2) begin
            errors++;
            $display("FAIL mode1_block: replays=%0d count=%0d want 4 2", nrep, c1);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[7] = '{6'h38, 6'h27, 6'h29, 6'h2A, 6'h2B, 6'h21, 6'h35};
        for (int m = 0; m < 2; m++) begin
            mode = m;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                rst = $urandom_range(0, 99) != 0;
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) < 6 ? {ops[$urandom_range(0, 6)], 26'($urandom)} : $urandom);
                #2;
                checks++;
                if (ob !== exp_out() || vb !== exp_v() || hb !== exp_v()) begin
                    errors++;
                    $display("FAIL rand%0d[%0d]: out=%h vld=%b hold=%b want %h %b", m, c, ob, vb, hb, exp_out(), exp_v());
                end
                tick();
                checks++;
                if (cb !== 4'(mq.size()) || ovb !== m_ovf) begin
                    errors++;
                    $display("FAIL rand%0d_cnt[%0d]: count=%0d ovf=%b want %0d %b", m, c, cb, ovb, mq.size(), m_ovf);
                end
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sw_remap();
        test_full();
        test_stall_empty();
        test_abort();
        test_mode1_block();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
